// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared types and constants for the VGA test-pattern scheduler
package vga_pkg;

    typedef enum logic [1:0] {
        PAT_SOLID   = 2'd0,
        PAT_BARS    = 2'd1,
        PAT_CHECKER = 2'd2,
        PAT_BORDER  = 2'd3
    } pattern_t;

    typedef enum logic {
        ST_AUTO   = 1'b0,
        ST_MANUAL = 1'b1
    } state_t;

    localparam int         BAR_WIDTH   = 80;
    localparam logic [2:0] COLOR_BLACK = 3'b000;
    localparam logic [2:0] COLOR_WHITE = 3'b111;

endpackage

// File: rtl/vga_debounce.sv
// rtl/vga_debounce.sv - two-flop synchronizer followed by a stable-level debounce counter
module vga_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic stable
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // Synchronize the raw level; idle (released) level is 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Count consecutive cycles the synced input disagrees with the stable level;
    // adopt the new level once it has disagreed for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            stable <= 1'b1;
        end else if (sync2 == stable) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt    <= '0;
            stable <= sync2;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/vga_pattern_scheduler.sv
// rtl/vga_pattern_scheduler.sv - frame-synchronous test-pattern selection and pixel generation
module vga_pattern_scheduler
    import vga_pkg::*;
#(
    parameter int FRAMES_PER_PATTERN = 60,
    parameter int DEBOUNCE_CYCLES    = 250000,
    parameter int H_ACTIVE           = 640,
    parameter int V_ACTIVE           = 480
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sw_r,
    input  logic       sw_g,
    input  logic       sw_b,
    input  logic       sw_auto,
    input  logic       btn_next,
    input  logic       vga_v_sync,
    input  logic       inDisplayArea,
    input  logic [9:0] CounterX,
    input  logic [9:0] CounterY,
    output logic [2:0] pixel,
    output logic [1:0] pattern_id,
    output logic       auto_mode,
    output logic       frame_tick
);

    localparam int FW = (FRAMES_PER_PATTERN > 2) ? $clog2(FRAMES_PER_PATTERN) : 1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_PATTERN - 1);

    logic [2:0]    col_s1;
    logic [2:0]    col_s2;
    logic          vs_s1;
    logic          vs_s2;
    logic          vs_d;
    logic          auto_stable;
    logic          btn_stable;
    logic          btn_prev;
    logic          press;
    state_t        state;
    state_t        state_next;
    logic [FW-1:0] fcnt;
    logic [FW-1:0] fcnt_next;
    logic [1:0]    pending;
    logic [1:0]    next_pending;
    logic [1:0]    pattern_q;
    logic [2:0]    color;
    logic [2:0]    bar_pix;
    logic [2:0]    pix_next;

    vga_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_auto (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw    (sw_auto),
        .stable (auto_stable)
    );

    vga_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_btn (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw    (btn_next),
        .stable (btn_stable)
    );

    // Synchronize color switches ({r,g,b}) and vsync; all idle high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_s1 <= 3'b111;
            col_s2 <= 3'b111;
            vs_s1  <= 1'b1;
            vs_s2  <= 1'b1;
            vs_d   <= 1'b1;
        end else begin
            col_s1 <= {sw_r, sw_g, sw_b};
            col_s2 <= col_s1;
            vs_s1  <= vga_v_sync;
            vs_s2  <= vs_s1;
            vs_d   <= vs_s2;
        end
    end

    // Frame tick on the synced vsync falling edge; remember last stable button level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_tick <= 1'b0;
            btn_prev   <= 1'b1;
        end else begin
            frame_tick <= vs_d & ~vs_s2;
            btn_prev   <= btn_stable;
        end
    end

    assign press     = btn_prev & ~btn_stable;
    assign auto_mode = (state == ST_AUTO);

    // Mode transitions, frame counting and pending-pattern arithmetic.
    always_comb begin
        state_next   = state;
        fcnt_next    = fcnt;
        next_pending = pending;
        case (state)
            ST_AUTO: begin
                if (auto_stable) begin
                    state_next = ST_MANUAL;
                end
                if (frame_tick) begin
                    if (fcnt == FRAME_LAST) begin
                        fcnt_next    = '0;
                        next_pending = pattern_q + 2'd1;
                    end else begin
                        fcnt_next = fcnt + 1'b1;
                    end
                end
            end
            ST_MANUAL: begin
                if (!auto_stable) begin
                    state_next = ST_AUTO;
                end
                fcnt_next = '0;
                if (press) begin
                    next_pending = pending + 2'd1;
                end
            end
            default: begin
                state_next = ST_AUTO;
                fcnt_next  = '0;
            end
        endcase
        if (state_next != state) begin
            fcnt_next = '0;
        end
    end

    // State, counter and pending registers; the visible pattern only moves on a frame tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_AUTO;
            fcnt      <= '0;
            pending   <= 2'd0;
            pattern_q <= 2'd0;
        end else begin
            state   <= state_next;
            fcnt    <= fcnt_next;
            pending <= next_pending;
            if (frame_tick) begin
                pattern_q <= next_pending;
            end
        end
    end

    assign pattern_id = pattern_q;

    // Bar index from a comparator chain: the lowest bar boundary above x wins.
    always_comb begin
        bar_pix = COLOR_BLACK;
        for (int i = 7; i >= 0; i--) begin
            if ({22'd0, CounterX} < (i + 1) * BAR_WIDTH) begin
                bar_pix = 3'(7 - i);
            end
        end
        if ({22'd0, CounterX} >= H_ACTIVE) begin
            bar_pix = COLOR_BLACK;
        end
    end

    // Select the pattern pixel; switches are active-low and output order is {R,B,G}.
    always_comb begin
        color    = {~col_s2[2], ~col_s2[0], ~col_s2[1]};
        pix_next = COLOR_BLACK;
        if (inDisplayArea) begin
            case (pattern_t'(pattern_q))
                PAT_SOLID:   pix_next = color;
                PAT_BARS:    pix_next = bar_pix;
                PAT_CHECKER: pix_next = (CounterX[5] ^ CounterY[5]) ? color : COLOR_BLACK;
                PAT_BORDER: begin
                    if (CounterX == 10'd0 || {22'd0, CounterX} == H_ACTIVE - 1 ||
                        CounterY == 10'd0 || {22'd0, CounterY} == V_ACTIVE - 1) begin
                        pix_next = COLOR_WHITE;
                    end
                end
                default:     pix_next = COLOR_BLACK;
            endcase
        end
    end

    // One-cycle registered pixel output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel <= COLOR_BLACK;
        end else begin
            pixel <= pix_next;
        end
    end

endmodule

// File: tb/tb_vga_pattern_scheduler.sv
// tb/tb_vga_pattern_scheduler.sv - testbench for vga_pattern_scheduler
module tb_vga_pattern_scheduler;

    localparam int F = 3;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sw_r, sw_g, sw_b, sw_auto, btn_next, vga_v_sync, inDisplayArea;
    logic [9:0] CounterX, CounterY;
    logic [2:0] pixel;
    logic [1:0] pattern_id;
    logic       auto_mode;
    logic       frame_tick;

    int checks = 0;
    int errors = 0;
    int tick_count = 0;

    int mpat, mpend, mcount;
    bit mauto;

    vga_pattern_scheduler #(
        .FRAMES_PER_PATTERN (F),
        .DEBOUNCE_CYCLES    (D),
        .H_ACTIVE           (640),
        .V_ACTIVE           (480)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sw_r          (sw_r),
        .sw_g          (sw_g),
        .sw_b          (sw_b),
        .sw_auto       (sw_auto),
        .btn_next      (btn_next),
        .vga_v_sync    (vga_v_sync),
        .inDisplayArea (inDisplayArea),
        .CounterX      (CounterX),
        .CounterY      (CounterY),
        .pixel         (pixel),
        .pattern_id    (pattern_id),
        .auto_mode     (auto_mode),
        .frame_tick    (frame_tick)
    );

    always #20 clk = ~clk;

    always @(negedge clk) begin
        if (frame_tick === 1'b1) tick_count++;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: pattern shown after one frame boundary.
    task automatic model_tick();
        if (mauto) begin
            mcount++;
            if (mcount == F) begin
                mcount = 0;
                mpend  = (mpat + 1) % 4;
            end
        end
        mpat = mpend;
    endtask

    function automatic logic [2:0] exp_pix(int pat, bit de, int x, int y, bit r, bit g, bit b);
        logic [2:0] col;
        col = {~r, ~b, ~g};
        if (!de) return 3'b000;
        case (pat)
            0: return col;
            1: return (x < 640) ? 3'(7 - x / 80) : 3'b000;
            2: return (((x / 32) + (y / 32)) % 2 == 1) ? col : 3'b000;
            3: return (x == 0 || x == 639 || y == 0 || y == 479) ? 3'b111 : 3'b000;
            default: return 3'b000;
        endcase
    endfunction

    task automatic vsync_frame();
        bit seen;
        int c0;
        seen = 0;
        vga_v_sync = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            step(1);
            if (frame_tick === 1'b1) seen = 1;
        end
        check("tick_seen", 32'(seen), 32'd1);
        if (seen) check("pat_hold_at_tick", 32'(pattern_id), 32'(mpat));
        model_tick();
        step(1);
        check("pat_after_tick", 32'(pattern_id), 32'(mpat));
        step(2);
        vga_v_sync = 1'b1;
        c0 = tick_count;
        step(8);
        check("single_tick", 32'(tick_count - c0), 32'd0);
    endtask

    task automatic press(input int low_cycles);
        btn_next = 1'b0;
        step(low_cycles);
        btn_next = 1'b1;
        step(8);
        if (!mauto && low_cycles >= D) mpend = (mpend + 1) % 4;
    endtask

    task automatic set_mode(input bit auto_on);
        sw_auto = auto_on ? 1'b0 : 1'b1;
        step(D + 6);
        mauto  = auto_on;
        mcount = 0;
        check("auto_mode", 32'(auto_mode), 32'(auto_on));
    endtask

    task automatic set_pattern(input int target);
        for (int k = 0; k < 4 && mpat != target; k++) begin
            press(8);
            vsync_frame();
        end
        check("set_pattern", 32'(pattern_id), 32'(target));
    endtask

    task automatic pix_check(input string tag, input int x, input int y, input bit de);
        CounterX = 10'(x);
        CounterY = 10'(y);
        inDisplayArea = de;
        step(1);
        check(tag, 32'(pixel), 32'(exp_pix(mpat, de, x, y, sw_r, sw_g, sw_b)));
    endtask

    task automatic random_pixels(input int n);
        for (int k = 0; k < n; k++) begin
            {sw_r, sw_g, sw_b} = 3'($urandom);
            step(3);
            pix_check("pix_rand", int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                      $urandom_range(0, 3) != 0);
        end
    endtask

    initial begin
        int p0;
        rst_n = 1'b0;
        {sw_r, sw_g, sw_b} = 3'b111;
        sw_auto = 1'b0;
        btn_next = 1'b1;
        vga_v_sync = 1'b1;
        inDisplayArea = 1'b1;
        CounterX = 10'd100;
        CounterY = 10'd50;
        mpat = 0; mpend = 0; mcount = 0; mauto = 1;

        // Reset state
        step(3);
        check("rst_pixel", 32'(pixel), 32'd0);
        check("rst_pattern", 32'(pattern_id), 32'd0);
        check("rst_auto", 32'(auto_mode), 32'd1);
        check("rst_tick", 32'(frame_tick), 32'd0);
        rst_n = 1'b1;
        step(20);
        check("no_tick_before_vsync", 32'(tick_count), 32'd0);
        check("auto_after_rst", 32'(auto_mode), 32'd1);

        // Auto cycling over 13 frames
        for (int k = 0; k < 13; k++) vsync_frame();
        check("auto_13_frames", 32'(pattern_id), 32'd0);

        // Manual stepping: two mid-frame presses
        set_mode(1'b0);
        p0 = mpat;
        press(8);
        press(8);
        check("pat_mid_frame", 32'(pattern_id), 32'(p0));
        vsync_frame();
        check("two_presses", 32'(pattern_id), 32'((p0 + 2) % 4));

        // Press coincident with frame_tick
        begin
            bit seen;
            seen = 0;
            p0 = mpat;
            btn_next = 1'b0;
            step(3);
            vga_v_sync = 1'b0;
            for (int i = 0; i < 12 && !seen; i++) begin
                step(1);
                if (frame_tick === 1'b1) seen = 1;
            end
            check("coinc_tick_seen", 32'(seen), 32'd1);
            mpend = (mpend + 1) % 4;
            mpat = mpend;
            step(1);
            check("coinc_press", 32'(pattern_id), 32'((p0 + 1) % 4));
            step(2);
            vga_v_sync = 1'b1;
            step(8);
            btn_next = 1'b1;
            step(8);
        end

        // Bounce rejection then one long press
        p0 = mpat;
        press(3);
        vsync_frame();
        check("bounce_rejected", 32'(pattern_id), 32'(p0));
        press(10);
        vsync_frame();
        check("long_press_once", 32'(pattern_id), 32'((p0 + 1) % 4));

        // Bars boundaries
        set_pattern(1);
        pix_check("bar_79", 79, 10, 1'b1);
        check("bar_79_lit", 32'(pixel), 32'd7);
        pix_check("bar_80", 80, 10, 1'b1);
        check("bar_80_lit", 32'(pixel), 32'd6);
        pix_check("bar_559", 559, 10, 1'b1);
        check("bar_559_lit", 32'(pixel), 32'd1);
        pix_check("bar_560", 560, 10, 1'b1);
        check("bar_560_lit", 32'(pixel), 32'd0);
        pix_check("bar_blank", 79, 10, 1'b0);
        check("bar_blank_lit", 32'(pixel), 32'd0);
        random_pixels(12);

        // Checker
        set_pattern(2);
        sw_r = 1'b0; sw_g = 1'b1; sw_b = 1'b1;
        step(3);
        pix_check("chk_32_0", 32, 0, 1'b1);
        check("chk_32_0_lit", 32'(pixel), 32'h4);
        pix_check("chk_32_32", 32, 32, 1'b1);
        check("chk_32_32_lit", 32'(pixel), 32'h0);
        random_pixels(12);

        // Border
        set_pattern(3);
        pix_check("brd_639", 639, 200, 1'b1);
        check("brd_639_lit", 32'(pixel), 32'h7);
        pix_check("brd_638", 638, 200, 1'b1);
        check("brd_638_lit", 32'(pixel), 32'h0);
        random_pixels(12);

        // Solid
        set_pattern(0);
        random_pixels(12);

        // Reset mid-frame
        set_pattern(3);
        CounterX = 10'd0;
        CounterY = 10'd0;
        inDisplayArea = 1'b1;
        step(2);
        #5;
        rst_n = 1'b0;
        #2;
        check("mid_rst_pixel", 32'(pixel), 32'd0);
        check("mid_rst_pattern", 32'(pattern_id), 32'd0);
        check("mid_rst_auto", 32'(auto_mode), 32'd1);
        check("mid_rst_tick", 32'(frame_tick), 32'd0);
        step(2);
        rst_n = 1'b1;
        mpat = 0; mpend = 0; mcount = 0; mauto = 0;
        step(D + 6);
        check("post_rst_manual", 32'(auto_mode), 32'd0);
        vsync_frame();
        check("post_rst_pattern", 32'(pattern_id), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
